sp1_ram_arb: RTL
================

# sp1_ram_arb

Two-port round-robin arbiter that shares one `sp1_ram` instance (single-port, synchronous, one-cycle read latency) between two requesters: port 0 (evaluator) and port 1 (heap loader/collector). It issues at most one RAM access per cycle, routes the read data back to the requester that issued the read, and supports a lock so one requester can run an uninterrupted read-modify-write sequence. It sits directly in front of `sp1_ram` and drives its `cs/we/adrs/din` pins.

## Interface
- AW, 10, address width; matches `sp1_ram` AW
- DW, 32, data width; matches `sp1_ram` DW

- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-low
- reqN  in  1  (N = 0,1) access request; held with we/adrs/din stable until granted
- lockN  in  1  keep ownership after this access
- weN  in  1  1 = write, 0 = read
- adrsN  in  AW  access address
- dinN  in  DW  write data
- gntN  out  1  combinational; access is issued at the posedge where reqN && gntN
- rvalidN  out  1  registered; rdataN valid this cycle
- rdataN  out  DW  read data; copy of ram_dout
- ram_cs  out  1  to `sp1_ram` cs
- ram_we  out  1  to `sp1_ram` we
- ram_adrs  out  AW  to `sp1_ram` adrs
- ram_din  out  DW  to `sp1_ram` din
- ram_dout  in  DW  from `sp1_ram` dout

## Operation
- State: `last` (1 bit, port granted last), `own` FSM {FREE, OWN0, OWN1}, `rpend` (2 bits, read issued last cycle per port).
- FREE: one request -> grant it. Both -> grant port != `last`. None -> no grant.
- OWNk: only port k may be granted (gntk = reqk); other port's gnt = 0 regardless of its req.
- Transitions at posedge: FREE -> OWNk when port k is granted with lockk=1. OWNk -> FREE when lockk=0 at posedge (with or without an access that cycle). Otherwise hold.
- `last` <= k on every issued access by port k (including in OWNk).
- RAM drive: ram_cs = reqk && gntk for the granted port; ram_we/adrs/din muxed from the granted port. No grant: ram_cs=0, ram_we=0, adrs/din = 0 (never X, never the ungranted port's values on cs/we).
- Read return: rpend[k] <= issued read by k; rvalidk = rpend[k]; rdataN = ram_dout both ports (consumer qualifies with rvalid). Writes produce no rvalid.
- Back-to-back accesses by either port allowed every cycle; no bubble on port switch.
- Reset (rst=0, async): last=1 (port 0 wins first tie), own=FREE, rpend=0. While rst=0, gnt0=gnt1=0 and ram_cs=0, ram_we=0 combinationally.

## Timing
- Cycle n: reqk=1, gntk=1 combinationally, ram_cs=1; RAM samples at posedge ending n.
- Read: rvalidk=1 and rdatak=RAM[adrs] during cycle n+1 (one posedge after issue).
- Write: RAM content updated at posedge ending n; a read of the same address issued in n+1 returns new data in n+2.
- Grant latency: 0 cycles when uncontended; contended, at most 1 extra access by the other port (FREE). In OWNk the other port waits until release.
- Release and new grant: lockk=0 at posedge ending n -> cycle n+1 is FREE arbitration.
- Reset asserted mid-read: rvalid cleared immediately; no return data delivered after reset release.
- Lock taken and dropped in the same access (lockk=0) never leaves FREE.

## Test plan
- Single port: port 0 write adrs 0x000 = 0xcafecafe, then read 0x000 -> gnt0 same cycle, rvalid0 one cycle after read issue, rdata0=0xcafecafe, rvalid1 stays 0.
- Contention: both request every cycle, port 0 reads 0x001..0x004 (preloaded 0x33333333, 0xcccccccc, 0x55555555, 0xaaaaaaaa), port 1 writes 0x3ff -> grants alternate 0,1,0,1 from reset; each rvalid0 carries the correct word in order.
- Lock: port 1 reads 0x3ff with lock1=1 then writes 0x3ff=0xbeefbeef with lock1=0 while port 0 requests continuously -> gnt0=0 for both cycles, port 0 granted the cycle after release; port 0 read of 0x3ff returns 0xbeefbeef.
- Idle safety: no requests, port inputs we/adrs/din driven X -> ram_cs=0, ram_we=0 every cycle, RAM contents unchanged (dump check 0x000 still 0xcafecafe).
- Reset: assert rst=0 for one cycle during a pending read and while in OWN0 -> gnt/ram_cs/rvalid low immediately; after release, first tie grants port 0, FSM FREE.
- Write-then-read hazard: port 1 writes 0x010=0x12345678, port 0 reads 0x010 in the next cycle -> rdata0=0x12345678.

Source files
------------

// File: rtl/sp1_ram_arb.sv
// sp1_ram_arb
// Round-robin arbiter sharing one single-port synchronous RAM (sp1_ram,
// one-cycle read latency) between port 0 (evaluator) and port 1 (heap
// loader/collector). At most one RAM access is issued per cycle. A requester
// may lock ownership to run an uninterrupted read-modify-write sequence.
//
// Handshake (both ports): a requester raises reqN with lockN/weN/adrsN/dinN
// and holds them stable until it sees gntN=1. gntN is combinational and is
// only ever asserted while reqN is high; the access is issued at the posedge
// where reqN && gntN. A read returns one cycle later as rvalidN=1 with
// rdataN; writes produce no rvalid. rdataN is a plain copy of ram_dout, so
// the consumer must qualify it with rvalidN.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req0/1, lock0/1, we0/1   per-port request, lock-after-access, write enable
//   adrs0/1, din0/1          per-port address and write data
//   gnt0/1                   combinational grant
//   rvalid0/1, rdata0/1      registered read-return qualifier, read data
//   ram_cs/we/adrs/din       drive of the sp1_ram pins
//   ram_dout                 sp1_ram read data
//   dbg_own                  ownership state: 0 = FREE, 1 = OWN0, 2 = OWN1
module sp1_ram_arb #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          lock0,
  input  logic          we0,
  input  logic [AW-1:0] adrs0,
  input  logic [DW-1:0] din0,
  input  logic          req1,
  input  logic          lock1,
  input  logic          we1,
  input  logic [AW-1:0] adrs1,
  input  logic [DW-1:0] din1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_adrs,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    dbg_own
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_e;

  own_e       own_q, own_d;
  logic       last_q;     // port granted most recently (1 after reset -> port 0 wins first tie)
  logic [1:0] rpend_q;    // read issued last cycle, per port
  logic       iss0, iss1;

  // Grant decision. Grants are suppressed while reset is asserted so the RAM
  // never sees a chip select during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (own_q)
        FREE: begin
          if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign iss0 = req0 && gnt0;
  assign iss1 = req1 && gnt1;

  // Ownership next state. An owner releases on any posedge where its lock
  // input is low, whether or not it accesses that cycle.
  always_comb begin
    own_d = own_q;
    case (own_q)
      FREE: begin
        if (iss0 && lock0)      own_d = OWN0;
        else if (iss1 && lock1) own_d = OWN1;
      end
      OWN0:    if (!lock0) own_d = FREE;
      OWN1:    if (!lock1) own_d = FREE;
      default: own_d = FREE;
    endcase
  end

  // RAM pin drive: idle cycles present all-zero pins, never the ungranted
  // port's (possibly undriven) values.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_adrs = '0;
    ram_din  = '0;
    if (iss0) begin
      ram_cs   = 1'b1;
      ram_we   = we0;
      ram_adrs = adrs0;
      ram_din  = din0;
    end else if (iss1) begin
      ram_cs   = 1'b1;
      ram_we   = we1;
      ram_adrs = adrs1;
      ram_din  = din1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q   <= FREE;
      last_q  <= 1'b1;
      rpend_q <= 2'b00;
    end else begin
      own_q <= own_d;
      if (iss0)      last_q <= 1'b0;
      else if (iss1) last_q <= 1'b1;
      rpend_q <= {iss1 && !we1, iss0 && !we0};
    end
  end

  assign rvalid0 = rpend_q[0];
  assign rvalid1 = rpend_q[1];
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;
  assign dbg_own = own_q;

endmodule
